count_checker: RTL and testbench
================================

Name: count_checker

Overview:
Downstream monitor for the 3-bit binary up-counter stage. It samples the counter value on a strobe and locks onto a valid modulo-2^WIDTH increment sequence. Once locked, it flags skipped or illegal values and counts wrap-arounds and errors. The result is a self-checking status block that sits next to the counter in the sequential-circuits datapath.

Parameters:
WIDTH, 3, width of the monitored count value.
SYNC_LEN, 4, number of consecutive correct increments required to reach lock (range 1..15).
ERR_LIMIT, 2, number of consecutive mismatches in LOCKED that force loss of lock (range 1..15).

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous reset, active-high.
cnt_in  input  WIDTH  count value from the upstream counter (bit0 = LSB).
cnt_valid  input  1  sample strobe; cnt_in is evaluated only when this is 1.
clr  input  1  synchronous clear of the statistics counters only.
locked  output  1  1 while the state is LOCKED.
state  output  2  00 UNLOCKED, 01 SYNC, 10 LOCKED (11 unused).
err_pulse  output  1  one-cycle pulse on a mismatch detected in LOCKED.
wrap_pulse  output  1  one-cycle pulse on a max->0 increment detected in LOCKED.
err_count  output  8  saturating count of err_pulse events.
wrap_count  output  16  saturating count of wrap_pulse events.

Behaviour:
- Reset values (rst=1 at a clock edge): state=UNLOCKED, locked=0, err_pulse=0, wrap_pulse=0, err_count=0, wrap_count=0. Internal registers also clear: last=0, good_run=0, bad_run=0. Reset overrides every other input.
- All outputs are registered. A sample at edge N is reflected on the outputs after edge N, i.e. one cycle of latency.
- Sample classification, applied only when cnt_valid=1:
  - INC: cnt_in == (last+1) mod 2^WIDTH. This includes the 2^WIDTH-1 -> 0 transition.
  - HOLD: cnt_in == last.
  - MISS: any other value.
- When cnt_valid=0: no state or register change; err_pulse=0 and wrap_pulse=0.
- UNLOCKED: any valid sample sets last<=cnt_in and good_run<=0, then moves to SYNC.
- SYNC:
  - INC: last<=cnt_in, good_run++. If the new good_run == SYNC_LEN, move to LOCKED with bad_run<=0.
  - HOLD: no change.
  - MISS: last<=cnt_in, good_run<=0, stay in SYNC. No err_pulse, no statistics update.
- LOCKED:
  - INC: last<=cnt_in, bad_run<=0. If last was 2^WIDTH-1 and cnt_in is 0, assert wrap_pulse and increment wrap_count.
  - HOLD: no change; bad_run is kept. A stalled or held counter is legal.
  - MISS: assert err_pulse, increment err_count, last<=cnt_in, bad_run++. If the new bad_run == ERR_LIMIT, move to SYNC with good_run<=0 and bad_run<=0; locked falls on the same edge.
- Pulses are asserted only for the single cycle following the triggering sample.
- locked is a registered decode of state == LOCKED.
- Saturation: err_count holds at 8'hFF and wrap_count holds at 16'hFFFF. Neither wraps.
- clr=1: err_count<=0 and wrap_count<=0. State, last and run counters are unaffected.
  - If clr coincides with an event, clr wins for the counters (they become 0), but the event pulse is still issued.
- Reset mid-operation: returns to UNLOCKED on the next edge. Any pulse from that cycle is suppressed.
- Arithmetic: the increment comparison is done modulo 2^WIDTH. good_run and bad_run are 4 bits.

Test Plan:
1. Reset then lock: rst=1 for 2 cycles, then cnt_in 0,1,2,3,4 with cnt_valid=1 each cycle -> state 00 -> 01 after sample 0; state=10 and locked=1 one cycle after sample 4; err_count=0.
2. Wrap: locked, feed 5,6,7,0,1 -> exactly one wrap_pulse, one cycle after the sample 0; wrap_count=1; no err_pulse.
3. Hold and strobe gaps: locked at 3, feed 3,3 with cnt_valid=1, then 2 idle cycles with cnt_valid=0, then 4 -> no pulses; locked stays 1; last becomes 4.
4. Single error, then recovery: locked at 2, feed 5 then 6 -> one err_pulse; err_count=1; locked stays 1 (bad_run reset by the INC to 6).
5. Loss of lock: locked at 1, feed 4 then 0 (two MISS samples) -> two err_pulses; err_count=2; state=01 and locked=0 after the second miss; then 1,2,3,4 -> relocks.
6. Saturation, clr and mid-operation reset: force 300 errors by toggling 0/4 in LOCKED with ERR_LIMIT=15 and relock between bursts -> err_count=255. Then assert clr together with a wrap event -> wrap_pulse=1 while wrap_count=0 and err_count=0. Then assert rst while locked -> state=00 next cycle with no pulses.

Source files
------------

// File: rtl/count_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | count_checker : locks onto a modulo-2^WIDTH increment sequence and flags  |
// |                 skipped values and wrap-arounds with saturating counters. |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module count_checker #(
  parameter int WIDTH     = 3,
  parameter int SYNC_LEN  = 4,
  parameter int ERR_LIMIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             cnt_valid,
  input  logic             clr,
  output logic             locked,
  output logic [1:0]       state,
  output logic             err_pulse,
  output logic             wrap_pulse,
  output logic [7:0]       err_count,
  output logic [15:0]      wrap_count
);

  localparam logic [1:0]       c_unlocked  = 2'b00;
  localparam logic [1:0]       c_sync      = 2'b01;
  localparam logic [1:0]       c_locked    = 2'b10;
  localparam logic [3:0]       c_sync_len  = 4'(SYNC_LEN);
  localparam logic [3:0]       c_err_limit = 4'(ERR_LIMIT);
  localparam logic [WIDTH-1:0] c_one       = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_max       = '1;

  logic [1:0]       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_last, w_last_nxt;
  logic [3:0]       r_good_run, w_good_nxt;
  logic [3:0]       r_bad_run, w_bad_nxt;
  logic             r_locked, w_locked_nxt;
  logic             r_err_pulse, w_err_pulse_nxt;
  logic             r_wrap_pulse, w_wrap_pulse_nxt;
  logic [7:0]       r_err_count, w_err_count_nxt;
  logic [15:0]      r_wrap_count, w_wrap_count_nxt;

  logic             w_inc;
  logic             w_hold;
  logic             w_miss;

  // Increment check relies on the WIDTH-bit sum wrapping naturally.
  assign w_inc  = (cnt_in == (r_last + c_one));
  assign w_hold = (cnt_in == r_last);
  assign w_miss = !w_inc && !w_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_unlocked;
      r_last       <= '0;
      r_good_run   <= '0;
      r_bad_run    <= '0;
      r_locked     <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_wrap_pulse <= 1'b0;
      r_err_count  <= '0;
      r_wrap_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last       <= w_last_nxt;
      r_good_run   <= w_good_nxt;
      r_bad_run    <= w_bad_nxt;
      r_locked     <= w_locked_nxt;
      r_err_pulse  <= w_err_pulse_nxt;
      r_wrap_pulse <= w_wrap_pulse_nxt;
      r_err_count  <= w_err_count_nxt;
      r_wrap_count <= w_wrap_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_good_nxt  = r_good_run;
    w_bad_nxt   = r_bad_run;
    if (cnt_valid) begin
      case (r_state)
        c_sync: begin
          if (w_inc) begin
            w_last_nxt = cnt_in;
            w_good_nxt = r_good_run + 4'd1;
            if (w_good_nxt == c_sync_len) begin
              w_state_nxt = c_locked;
              w_bad_nxt   = '0;
            end
          end else if (w_miss) begin
            w_last_nxt = cnt_in;
            w_good_nxt = '0;
          end
        end
        c_locked: begin
          if (w_inc) begin
            w_last_nxt = cnt_in;
            w_bad_nxt  = '0;
          end else if (w_miss) begin
            w_last_nxt = cnt_in;
            w_bad_nxt  = r_bad_run + 4'd1;
            if (w_bad_nxt == c_err_limit) begin
              w_state_nxt = c_sync;
              w_good_nxt  = '0;
              w_bad_nxt   = '0;
            end
          end
        end
        default: begin
          // UNLOCKED (and the unused encoding) take any sample as the seed.
          w_last_nxt  = cnt_in;
          w_good_nxt  = '0;
          w_state_nxt = c_sync;
        end
      endcase
    end
  end

  always_comb begin
    w_locked_nxt     = (w_state_nxt == c_locked);
    w_err_pulse_nxt  = cnt_valid && (r_state == c_locked) && w_miss;
    w_wrap_pulse_nxt = cnt_valid && (r_state == c_locked) && w_inc &&
                       (r_last == c_max) && (cnt_in == '0);
    w_err_count_nxt  = r_err_count;
    w_wrap_count_nxt = r_wrap_count;
    if (w_err_pulse_nxt && (r_err_count != 8'hFF)) begin
      w_err_count_nxt = r_err_count + 8'd1;
    end
    if (w_wrap_pulse_nxt && (r_wrap_count != 16'hFFFF)) begin
      w_wrap_count_nxt = r_wrap_count + 16'd1;
    end
    // Clearing wins over a same-cycle event; the pulse itself still fires.
    if (clr) begin
      w_err_count_nxt  = '0;
      w_wrap_count_nxt = '0;
    end
  end

  assign locked     = r_locked;
  assign state      = r_state;
  assign err_pulse  = r_err_pulse;
  assign wrap_pulse = r_wrap_pulse;
  assign err_count  = r_err_count;
  assign wrap_count = r_wrap_count;

endmodule
`default_nettype wire

// File: tb/tb_count_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_count_checker : directed vector table plus randomized model checking.  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_count_checker;

  localparam int W         = 3;
  localparam int MOD       = 1 << W;
  localparam int SYNC_LEN  = 4;
  localparam int ERR_LIMIT = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] cnt_in;
  logic         cnt_valid;
  logic         clr;
  logic         locked;
  logic [1:0]   state;
  logic         err_pulse;
  logic         wrap_pulse;
  logic [7:0]   err_count;
  logic [15:0]  wrap_count;

  count_checker #(.WIDTH(W), .SYNC_LEN(SYNC_LEN), .ERR_LIMIT(ERR_LIMIT)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_valid(cnt_valid), .clr(clr),
    .locked(locked), .state(state), .err_pulse(err_pulse),
    .wrap_pulse(wrap_pulse), .err_count(err_count), .wrap_count(wrap_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 unlocked, 1 syncing, 2 locked.
  int m_phase = 0, m_last = 0, m_good = 0, m_bad = 0;
  int m_errc = 0, m_wrapc = 0, m_ep = 0, m_wp = 0;

  task automatic model_step(input bit r, input bit v, input bit c, input int cnt);
    bit is_inc, is_hold;
    if (r) begin
      m_phase = 0; m_last = 0; m_good = 0; m_bad = 0;
      m_errc = 0; m_wrapc = 0; m_ep = 0; m_wp = 0;
      return;
    end
    m_ep = 0;
    m_wp = 0;
    if (v) begin
      is_inc  = (cnt == (m_last + 1) % MOD);
      is_hold = (cnt == m_last);
      if (m_phase == 0) begin
        m_last = cnt; m_good = 0; m_phase = 1;
      end else if (m_phase == 1) begin
        if (is_inc) begin
          m_last = cnt; m_good++;
          if (m_good == SYNC_LEN) begin m_phase = 2; m_bad = 0; end
        end else if (!is_hold) begin
          m_last = cnt; m_good = 0;
        end
      end else begin
        if (is_inc) begin
          if (m_last == MOD - 1 && cnt == 0) begin
            m_wp = 1;
            if (m_wrapc < 65535) m_wrapc++;
          end
          m_last = cnt; m_bad = 0;
        end else if (!is_hold) begin
          m_ep = 1;
          if (m_errc < 255) m_errc++;
          m_last = cnt; m_bad++;
          if (m_bad == ERR_LIMIT) begin m_phase = 1; m_good = 0; m_bad = 0; end
        end
      end
    end
    if (c) begin m_errc = 0; m_wrapc = 0; end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit v, input bit c, input int cnt);
    rst = r; cnt_valid = v; clr = c; cnt_in = W'(cnt);
    @(posedge clk);
    #1;
    model_step(r, v, c, cnt);
  endtask

  task automatic check_all(input string tag, input int st, input int lk, input int ep,
                           input int wp, input int ec, input int wc);
    check({tag, ".state"}, int'(state), st);
    check({tag, ".locked"}, int'(locked), lk);
    check({tag, ".err_pulse"}, int'(err_pulse), ep);
    check({tag, ".wrap_pulse"}, int'(wrap_pulse), wp);
    check({tag, ".err_count"}, int'(err_count), ec);
    check({tag, ".wrap_count"}, int'(wrap_count), wc);
  endtask

  typedef struct {
    bit r, v, c;
    int cnt;
    int st, lk, ep, wp, ec, wc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input bit v, input bit c, input int cnt, input int st,
                     input int lk, input int ep, input int wp, input int ec, input int wc);
    vec_t t;
    t.r = r; t.v = v; t.c = c; t.cnt = cnt;
    t.st = st; t.lk = lk; t.ep = ep; t.wp = wp; t.ec = ec; t.wc = wc;
    vecs.push_back(t);
  endtask

  initial begin
    int guard;
    rst = 1'b1; cnt_valid = 1'b0; clr = 1'b0; cnt_in = '0;

    //   r v c cnt  st lk ep wp ec wc
    add(1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0,  1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1,  1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 2,  1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 3,  1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4,  2, 1, 0, 0, 0, 0);
    add(0, 1, 0, 5,  2, 1, 0, 0, 0, 0);
    add(0, 1, 0, 6,  2, 1, 0, 0, 0, 0);
    add(0, 1, 0, 7,  2, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0,  2, 1, 0, 1, 0, 1);
    add(0, 1, 0, 1,  2, 1, 0, 0, 0, 1);
    add(0, 1, 0, 2,  2, 1, 0, 0, 0, 1);
    add(0, 1, 0, 3,  2, 1, 0, 0, 0, 1);
    add(0, 1, 0, 3,  2, 1, 0, 0, 0, 1);
    add(0, 1, 0, 3,  2, 1, 0, 0, 0, 1);
    add(0, 0, 0, 5,  2, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0,  2, 1, 0, 0, 0, 1);
    add(0, 1, 0, 4,  2, 1, 0, 0, 0, 1);
    add(0, 1, 0, 7,  2, 1, 1, 0, 1, 1);
    add(0, 1, 0, 0,  2, 1, 0, 1, 1, 2);
    add(0, 1, 0, 1,  2, 1, 0, 0, 1, 2);
    add(0, 1, 0, 4,  2, 1, 1, 0, 2, 2);
    add(0, 1, 0, 0,  1, 0, 1, 0, 3, 2);
    add(0, 1, 0, 1,  1, 0, 0, 0, 3, 2);
    add(0, 1, 0, 2,  1, 0, 0, 0, 3, 2);
    add(0, 1, 0, 3,  1, 0, 0, 0, 3, 2);
    add(0, 1, 0, 4,  2, 1, 0, 0, 3, 2);
    add(0, 0, 1, 0,  2, 1, 0, 0, 0, 0);
    add(0, 1, 0, 5,  2, 1, 0, 0, 0, 0);
    add(0, 1, 0, 6,  2, 1, 0, 0, 0, 0);
    add(0, 1, 0, 7,  2, 1, 0, 0, 0, 0);
    add(0, 1, 1, 0,  2, 1, 0, 1, 0, 0);
    add(1, 1, 0, 1,  0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 3,  1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 6,  1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 6,  1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 7,  1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0,  1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1,  1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 2,  2, 1, 0, 0, 0, 0);
    add(0, 1, 0, 5,  2, 1, 1, 0, 1, 0);
    add(0, 1, 0, 5,  2, 1, 0, 0, 1, 0);
    add(0, 1, 0, 0,  1, 0, 1, 0, 2, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].v, vecs[i].c, vecs[i].cnt);
      check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].lk, vecs[i].ep,
                vecs[i].wp, vecs[i].ec, vecs[i].wc);
    end

    // Randomized traffic biased toward legal increments so lock is reached often.
    for (int i = 0; i < 2000; i++) begin
      int sel, cnt;
      bit v, c, r;
      sel = $urandom_range(0, 99);
      if (sel < 60)      cnt = (m_last + 1) % MOD;
      else if (sel < 75) cnt = m_last;
      else               cnt = $urandom_range(0, MOD - 1);
      v = ($urandom_range(0, 99) < 80);
      c = ($urandom_range(0, 99) < 3);
      r = ($urandom_range(0, 199) < 3);
      drive(r, v, c, cnt);
      check_all($sformatf("rnd%0d", i), m_phase, (m_phase == 2) ? 1 : 0, m_ep, m_wp,
                m_errc, m_wrapc);
    end

    // Drive misses while locked and increments otherwise until err_count saturates.
    drive(0, 0, 1, 0);
    check_all("satclr", m_phase, (m_phase == 2) ? 1 : 0, m_ep, m_wp, m_errc, m_wrapc);
    guard = 0;
    while (m_errc < 255 && guard < 5000) begin
      if (m_phase == 2) drive(0, 1, 0, (m_last + 4) % MOD);
      else              drive(0, 1, 0, (m_last + 1) % MOD);
      check_all($sformatf("sat%0d", guard), m_phase, (m_phase == 2) ? 1 : 0, m_ep, m_wp,
                m_errc, m_wrapc);
      guard++;
    end
    for (int i = 0; i < 120; i++) begin
      if (m_phase == 2) drive(0, 1, 0, (m_last + 4) % MOD);
      else              drive(0, 1, 0, (m_last + 1) % MOD);
      check_all($sformatf("sathold%0d", i), m_phase, (m_phase == 2) ? 1 : 0, m_ep, m_wp,
                m_errc, m_wrapc);
    end
    check("err_count_saturated", int'(err_count), 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
